// File: rtl/hex_scroll_pkg.sv
// rtl/hex_scroll_pkg.sv - shared character codes, message table and FSM state type
package hex_scroll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Codes understood by the downstream 3-bit seven-segment decoders
  localparam logic [2:0] CH_D     = 3'd0;
  localparam logic [2:0] CH_E     = 3'd1;
  localparam logic [2:0] CH_1     = 3'd2;
  localparam logic [2:0] CH_0     = 3'd3;
  localparam logic [2:0] CH_2     = 3'd4;
  localparam logic [2:0] CH_BLANK = 3'd7;

  localparam int MSG_LEN = 8;

  // MSG[0] is the rightmost element of the concatenation
  localparam logic [MSG_LEN-1:0][2:0] MSG = {
    CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_D, CH_E, CH_2
  };

  function automatic logic [2:0] msg_char(input logic [2:0] digit, input logic [2:0] rot);
    logic [2:0] idx;
    idx = digit - rot;
    return MSG[idx];
  endfunction

endpackage

// File: rtl/hex_scroll_ctrl_tick_gen.sv
// rtl/hex_scroll_ctrl_tick_gen.sv - scroll-step prescaler with terminal-count strobe
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic done
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holding en low freezes the count so a resumed interval finishes where it left off
  assign done = en & ~clr & (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// rtl/hex_scroll_ctrl.sv - run/pause/step scroller rotating a fixed message over 8 hex digits
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int NUM_DISP = 8,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     step,
  input  logic                     clear,
  input  logic                     dir,
  output logic [NUM_DISP-1:0][2:0] char_vec,
  output logic [2:0]               pos,
  output logic [1:0]               state,
  output logic                     tick
);

  state_e     state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic       tick_q, tick_d;
  logic       start_q, pause_q, step_q;
  logic       start_edge, pause_edge, step_edge;
  logic       advance;
  logic       tg_en, tg_clr, tg_done;

  assign start_edge = start & ~start_q;
  assign pause_edge = pause & ~pause_q;
  assign step_edge  = step  & ~step_q;

  assign tg_en  = (state_q == ST_RUN);
  assign tg_clr = clear | (state_q == ST_IDLE);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tg_en),
    .clr  (tg_clr),
    .done (tg_done)
  );

  // Request priority: clear, then pause, then start, then step
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tick_d  = 1'b0;
    advance = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      pos_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_edge && !pause_edge) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pause_edge) state_d = ST_PAUSE;
          advance = tg_done;
        end
        ST_PAUSE: begin
          if (pause_edge) begin
            state_d = ST_PAUSE;
          end else if (start_edge) begin
            state_d = ST_RUN;
          end else if (step_edge) begin
            advance = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (advance) begin
        pos_d = dir ? pos_q - 3'd1 : pos_q + 3'd1;
      end
      tick_d = advance;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_q   <= 3'd0;
      tick_q  <= 1'b0;
      start_q <= 1'b1;
      pause_q <= 1'b1;
      step_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tick_q  <= tick_d;
      start_q <= start;
      pause_q <= pause;
      step_q  <= step;
    end
  end

  for (genvar i = 0; i < NUM_DISP; i++) begin : g_digit
    assign char_vec[i] = msg_char(3'(i), pos_q);
  end

  assign pos   = pos_q;
  assign state = state_q;
  assign tick  = tick_q;

endmodule
